// File: rtl/nihilist_stream_encryptor_if.sv
// rtl/nihilist_stream_encryptor_if.sv - plaintext/cipher streams and key-write port of the Nihilist encryptor
interface nihilist_stream_encryptor_if #(
    parameter int SEC_LEN = 3
);
    localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_code;
    logic             out_last;
    logic             out_err;
    logic             key_wr_en;
    logic [IDX_W-1:0] key_wr_idx;
    logic [7:0]       key_wr_char;
    logic             key_wr_err;
    logic             key_locked;

    modport master (
        output in_valid, in_char, in_last, out_ready, key_wr_en, key_wr_idx, key_wr_char,
        input  in_ready, out_valid, out_code, out_last, out_err, key_wr_err, key_locked
    );

    modport slave (
        input  in_valid, in_char, in_last, out_ready, key_wr_en, key_wr_idx, key_wr_char,
        output in_ready, out_valid, out_code, out_last, out_err, key_wr_err, key_locked
    );
endinterface

// File: rtl/nihilist_stream_encryptor.sv
// rtl/nihilist_stream_encryptor.sv - Polybius/Nihilist encryptor with rotating writable key
module nihilist_stream_encryptor #(
    parameter int                   SEC_LEN     = 3,
    parameter logic [8*SEC_LEN-1:0] DEFAULT_KEY = "KEY"
) (
    input  logic                          clk,
    input  logic                          rst,
    nihilist_stream_encryptor_if.slave    bus
);
    localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t           state, state_nxt;
    logic [7:0]       key_q [SEC_LEN];
    logic [IDX_W-1:0] key_idx;
    logic [7:0]       char_q;
    logic             last_q;
    logic [7:0]       code_q;
    logic             code_last_q;
    logic             code_err_q;
    logic             wr_err_q;

    // Case-folds and merges J into I; returns 0 for anything that is not a letter.
    function automatic logic [7:0] norm(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7a) ? (c - 8'd32) : c;
        if (u == "J")
            u = "I";
        return (u >= 8'h41 && u <= 8'h5a) ? u : 8'd0;
    endfunction

    function automatic logic [7:0] num(input logic [7:0] c);
        case (c)
            "M": return 8'd11; "I": return 8'd12; "H": return 8'd13; "A": return 8'd14; "B": return 8'd15;
            "C": return 8'd21; "D": return 8'd22; "E": return 8'd23; "F": return 8'd24; "G": return 8'd25;
            "K": return 8'd31; "L": return 8'd32; "N": return 8'd33; "O": return 8'd34; "P": return 8'd35;
            "Q": return 8'd41; "R": return 8'd42; "S": return 8'd43; "T": return 8'd44; "U": return 8'd45;
            "V": return 8'd51; "W": return 8'd52; "X": return 8'd53; "Y": return 8'd54; "Z": return 8'd55;
            default: return 8'd0;
        endcase
    endfunction

    logic [7:0] plain_num;
    logic [7:0] key_num;
    logic       plain_ok;
    logic [7:0] wr_norm;
    logic       locked;
    logic       wr_ok;

    always_comb begin
        plain_num = num(norm(char_q));
        key_num   = num(key_q[key_idx]);
        plain_ok  = (plain_num != 8'd0);
        wr_norm   = norm(bus.key_wr_char);
        locked    = (state != IDLE) || (key_idx != '0);
        wr_ok     = !locked && (wr_norm != 8'd0) && (32'(bus.key_wr_idx) < SEC_LEN);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CONV;
            CONV:    state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_idx     <= '0;
            char_q      <= 8'd0;
            last_q      <= 1'b0;
            code_q      <= 8'd0;
            code_last_q <= 1'b0;
            code_err_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            for (int i = 0; i < SEC_LEN; i++)
                key_q[i] <= DEFAULT_KEY[8*(SEC_LEN-1-i) +: 8];
        end else begin
            if (state == IDLE && bus.in_valid) begin
                char_q <= bus.in_char;
                last_q <= bus.in_last;
            end
            if (state == CONV) begin
                code_q      <= plain_ok ? (plain_num + key_num) : 8'd0;
                code_last_q <= last_q;
                code_err_q  <= !plain_ok;
                if (last_q)
                    key_idx <= '0;
                else if (plain_ok)
                    key_idx <= (key_idx == IDX_W'(SEC_LEN-1)) ? '0 : key_idx + 1'b1;
            end
            // A write in the accepting IDLE cycle lands before CONV reads the key.
            wr_err_q <= 1'b0;
            if (bus.key_wr_en) begin
                if (wr_ok)
                    key_q[bus.key_wr_idx] <= wr_norm;
                else
                    wr_err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == HOLD);
    assign bus.out_code   = code_q;
    assign bus.out_last   = code_last_q;
    assign bus.out_err    = code_err_q;
    assign bus.key_wr_err = wr_err_q;
    assign bus.key_locked = locked;
endmodule

// File: tb/tb_nihilist_stream_encryptor.sv
// tb/tb_nihilist_stream_encryptor.sv - directed self-checking bench for nihilist_stream_encryptor
module tb_nihilist_stream_encryptor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    nihilist_stream_encryptor_if #(.SEC_LEN(3)) bus ();

    nihilist_stream_encryptor #(.SEC_LEN(3), .DEFAULT_KEY("KEY")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("in_ready_timeout", 0, 1);
    endtask

    // Accept at edge N, expect out_valid low after N and high after N+1.
    task automatic send(input string name, input logic [7:0] ch, input logic last,
                        input int exp_code, input int exp_err);
        @(negedge clk);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        bus.in_last  = last;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat_lo"}, bus.out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_code"}, bus.out_code, exp_code);
        chk({name, "_err"}, bus.out_err, exp_err);
        chk({name, "_last"}, bus.out_last, last);
        @(posedge clk);
    endtask

    task automatic key_write(input logic [1:0] idx, input logic [7:0] ch, input int exp_err);
        @(negedge clk);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = idx;
        bus.key_wr_char = ch;
        @(posedge clk);
        #1 bus.key_wr_en = 1'b0;
        @(negedge clk);
        chk("wr_err_pulse", bus.key_wr_err, exp_err);
        @(negedge clk);
        chk("wr_err_clear", bus.key_wr_err, 0);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_char     = 8'd0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;
        bus.key_wr_en   = 1'b0;
        bus.key_wr_idx  = 2'd0;
        bus.key_wr_char = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_code", bus.out_code, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_key_locked", bus.key_locked, 0);
        chk("rst_wr_err", bus.key_wr_err, 0);

        send("hello_h", "H", 1'b0, 44, 0);
        send("hello_e", "E", 1'b0, 46, 0);
        send("hello_l1", "L", 1'b0, 86, 0);
        send("hello_l2", "L", 1'b0, 63, 0);
        send("hello_o", "O", 1'b1, 57, 0);
        @(negedge clk);
        chk("hello_unlocked", bus.key_locked, 0);

        send("zz0", "Z", 1'b0, 86, 0);
        @(negedge clk);
        chk("zz_locked", bus.key_locked, 1);
        send("zz1", "Z", 1'b0, 78, 0);
        send("zz2", "Z", 1'b0, 109, 0);
        send("zz3", "Z", 1'b0, 86, 0);
        send("zz_end", "M", 1'b1, 34, 0);

        send("lower_m", "m", 1'b1, 42, 0);
        send("lower_j", "j", 1'b1, 43, 0);

        send("inv_m0", "M", 1'b0, 42, 0);
        send("inv_5", "5", 1'b0, 0, 1);
        send("inv_m1", "M", 1'b1, 34, 0);

        key_write(2'd0, "a", 0);
        send("newkey_m", "M", 1'b1, 25, 0);

        send("msg_m0", "M", 1'b0, 25, 0);
        key_write(2'd0, "B", 1);
        send("msg_m1", "M", 1'b1, 34, 0);
        send("keep_m", "M", 1'b1, 25, 0);
        key_write(2'd0, "7", 1);
        key_write(2'd3, "B", 1);
        send("bad_wr_m", "M", 1'b1, 25, 0);

        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_char   = "Q";
        bus.in_last   = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_code", bus.out_code, 55);
            chk("hold_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_hold_valid", bus.out_valid, 0);
        chk("rst_hold_code", bus.out_code, 0);
        chk("rst_hold_ready", bus.in_ready, 1);
        send("default_m", "M", 1'b1, 42, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/nihilist_stream_encryptor.md
Name: nihilist_stream_encryptor

Overview:
- Sequential Polybius/Nihilist encryptor that sits directly upstream of the combinational decryptor and produces the cipher bytes it consumes.
- Accepts one plaintext character per valid/ready handshake and maps it through the fixed 5x5 table (rows MIHAB, CDEFG, KLNOP, QRSTU, VWXYZ; J absent).
- Adds the two-digit number of the current key character and emits the cipher byte on a valid/ready output.
- The key is held in a writable register file and rotates per character, restarting at each message boundary.

Parameters:
- SEC_LEN, 3: number of key characters.
- DEFAULT_KEY, "KEY" (8*SEC_LEN bits, first character in the MS byte): key loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext character present
- in_ready  out  1  block can accept a character
- in_char  in  8  ASCII plaintext character
- in_last  in  1  marks the final character of a message
- out_valid  out  1  cipher byte present
- out_ready  in  1  downstream accepts the byte
- out_code  out  8  cipher value, binary
- out_last  out  1  in_last of the source character
- out_err  out  1  source character was invalid
- key_wr_en  in  1  key write strobe
- key_wr_idx  in  $clog2(SEC_LEN) (min 1)  key slot to write
- key_wr_char  in  8  ASCII key character
- key_wr_err  out  1  one-cycle pulse: the write was rejected
- key_locked  out  1  high while a message is in progress or the FSM is not IDLE

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything, including mid-message):
  - state=IDLE, key_idx=0, key=DEFAULT_KEY.
  - out_valid=0, out_code=0, out_last=0, out_err=0, key_wr_err=0.
  - in_ready=1 in the first cycle after reset.
- FSM IDLE -> CONV -> HOLD -> IDLE:
  - IDLE: in_ready=1. On in_valid, latch in_char and in_last, then go to CONV.
  - CONV: in_ready=0. Compute and register out_code, out_last and out_err, then go to HOLD.
  - HOLD: out_valid=1 and outputs are stable. When out_ready=1, go to IDLE; out_valid=0 on the next cycle.
  - Latency: accept at edge N gives out_valid at N+2. Maximum throughput is one character per 3 cycles.
- Normalisation, applied to both in_char and key_wr_char:
  - 'a'-'z' becomes 'A'-'Z'.
  - 'J' becomes 'I'.
  - Anything else is invalid.
- Arithmetic:
  - num(ch) = row*10 + col, with row and col in 1..5.
  - out_code = num(plain) + num(key[key_idx]). Range is 22..110, fits in 8 bits, no wrap.
- Invalid plaintext character: out_code=0, out_err=1, key_idx is not advanced.
- key_idx update at the CONV edge:
  - If in_last: key_idx=0, even when the character is invalid.
  - Else if valid: key_idx = (key_idx==SEC_LEN-1) ? 0 : key_idx+1.
  - Else: unchanged.
- key_locked = (state!=IDLE) || (key_idx!=0).
- Key writes:
  - Applied at the edge only when key_locked=0, the normalised char is valid, and key_wr_idx<SEC_LEN.
  - Otherwise the key is unchanged and key_wr_err=1 for exactly the next cycle.
  - A write and an input accept in the same IDLE cycle: the write is applied first, and the accepted character uses the new key.
- Back-pressure: in HOLD with out_ready=0, out_* stays unchanged indefinitely and in_ready stays 0.
- Message framing is not checked; a message longer than SEC_LEN simply rotates the key.

Test Plan:
- Reset, then "HELLO" with in_last on 'O', out_ready=1 -> out_code 44,46,86,63,57; out_last only on the 5th byte; key_locked=0 afterwards; each out_valid 2 cycles after its accept.
- "ZZZZ" with no in_last -> 86,78,109,86 (key wraps Y->K); key_locked=1 after the first accept.
- "m", then "j" (last) -> 42, 43 (lowercase folded, J->I); out_err=0.
- "M", '5', "M" (last) -> 42, 0 with out_err=1, 34 (key index held across the invalid char).
- Idle write idx0='A', then "M" (last) -> 25. Write during a message, or with key_wr_char='7' -> key_wr_err pulse for one cycle, key unchanged.
- Hold out_ready low 5 cycles in HOLD -> code stable, in_ready=0. Assert rst mid-HOLD -> out_valid=0 next cycle; "M" then gives 42 (DEFAULT_KEY restored).
